mmio_timer_bank: RTL

- Parametrised successor to the single free-running MMIO timer: one shared microsecond tick, a 64-bit timestamp, and NUM_CH independent down-counting channels with one-shot/periodic modes.
- Channels have sticky expiry flags and a combined interrupt line.
- Sits on the data-memory bus behind the MMU select decode, alongside the LED/SEG/keyboard peripherals.

---
 rtl/mmio_timer_bank.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mmio_timer_bank.sv
// MMIO timer bank: shared prescaled tick, 64-bit timestamp, NUM_CH one-shot/periodic down-counters.
// Define TIMER_FREEZE_EN to add a freeze input that pauses all counting.
module mmio_timer_bank #(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_WIDTH    = 32,
  parameter logic [31:0] PRESCALE_RST = 32'd50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic        re,
  input  logic [7:0]  addr,
  input  logic [31:0] din,
`ifdef TIMER_FREEZE_EN
  input  logic        freeze,
`endif
  output logic [31:0] dout,
  output logic        irq
);

  logic [31:0] prescale_q, prescale_d;
  logic [31:0] presc_cnt_q, presc_cnt_d;
  logic [63:0] tick_q, tick_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] dout_q, dout_d;
  logic        irq_q, irq_d;
  logic [NUM_CH-1:0] status_q, status_d;
  logic [NUM_CH-1:0] en_q, en_d, per_q, per_d, ie_q, ie_d;
  logic [CNT_WIDTH-1:0] load_q  [NUM_CH];
  logic [CNT_WIDTH-1:0] load_d  [NUM_CH];
  logic [CNT_WIDTH-1:0] count_q [NUM_CH];
  logic [CNT_WIDTH-1:0] count_d [NUM_CH];

  logic [NUM_CH-1:0] ctrl_hit, load_hit, per_eff, expire;
  logic [5:0]  widx;
  logic [31:0] presc_last;
  logic [31:0] rdata;
  logic        wr, rd, run, tick;

  assign widx = 6'(addr >> 2);
  assign wr   = sel & we;
  assign rd   = sel & re;

`ifdef TIMER_FREEZE_EN
  assign run = ~freeze;
`else
  assign run = 1'b1;
`endif

  // A PRESCALE of zero behaves like one: a tick every cycle.
  assign presc_last = (prescale_q == 32'd0) ? 32'd0 : prescale_q - 32'd1;
  assign tick       = run && (presc_cnt_q == presc_last);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_dec
      assign ctrl_hit[gi] = wr && (widx == {4'(gi + 1), 2'd0});
      assign load_hit[gi] = wr && (widx == {4'(gi + 1), 2'd1});
      assign per_eff[gi]  = ctrl_hit[gi] ? din[1] : per_q[gi];
    end
  endgenerate

  always_comb begin
    prescale_d  = prescale_q;
    presc_cnt_d = presc_cnt_q;
    tick_d      = tick_q;
    if (run) begin
      presc_cnt_d = tick ? 32'd0 : presc_cnt_q + 32'd1;
      if (tick) tick_d = tick_q + 64'd1;
    end
    if (wr && widx == 6'd2) begin
      prescale_d  = din;
      presc_cnt_d = 32'd0;
    end
  end

  // Channel FSM: EN is the state bit (IDLE/RUN). A CTRL write with EN=0 suppresses
  // that cycle's tick, and an EN 0->1 write reloads instead of counting.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      en_d[n]    = en_q[n];
      per_d[n]   = per_q[n];
      ie_d[n]    = ie_q[n];
      load_d[n]  = load_q[n];
      count_d[n] = count_q[n];
      expire[n]  = 1'b0;
      if (ctrl_hit[n]) begin
        en_d[n]  = din[0];
        per_d[n] = din[1];
        ie_d[n]  = din[2];
      end
      if (ctrl_hit[n] && din[0] && !en_q[n]) begin
        count_d[n] = load_q[n];
      end else if (en_q[n] && tick && !(ctrl_hit[n] && !din[0]) &&
                   count_q[n] != '0) begin
        if (count_q[n] == CNT_WIDTH'(1)) begin
          expire[n] = 1'b1;
          if (per_eff[n]) begin
            count_d[n] = load_q[n];
          end else begin
            count_d[n] = '0;
            en_d[n]    = 1'b0;
          end
        end else begin
          count_d[n] = count_q[n] - CNT_WIDTH'(1);
        end
      end
      if (load_hit[n]) load_d[n] = din[CNT_WIDTH-1:0];
    end
    // Expiry set takes priority over a same-cycle write-1-to-clear.
    if (wr && widx == 6'd3) status_d = (status_q & ~din[NUM_CH-1:0]) | expire;
    else                    status_d = status_q | expire;
  end

  always_comb begin
    rdata = 32'd0;
    case (widx)
      6'd0:    rdata = tick_q[31:0];
      6'd1:    rdata = shadow_q;
      6'd2:    rdata = prescale_q;
      6'd3:    rdata = 32'(status_q);
      default: begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (widx[5:2] == 4'(n + 1)) begin
            case (widx[1:0])
              2'd0:    rdata = {29'd0, ie_q[n], per_q[n], en_q[n]};
              2'd1:    rdata = 32'(load_q[n]);
              2'd2:    rdata = 32'(count_q[n]);
              default: rdata = 32'd0;
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    dout_d   = rd ? rdata : dout_q;
    shadow_d = (rd && widx == 6'd0) ? tick_q[63:32] : shadow_q;
    irq_d    = |(status_q & ie_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescale_q  <= PRESCALE_RST;
      presc_cnt_q <= 32'd0;
      tick_q      <= 64'd0;
      shadow_q    <= 32'd0;
      dout_q      <= 32'd0;
      irq_q       <= 1'b0;
      status_q    <= '0;
      en_q        <= '0;
      per_q       <= '0;
      ie_q        <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        load_q[n]  <= '0;
        count_q[n] <= '0;
      end
    end else begin
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
      tick_q      <= tick_d;
      shadow_q    <= shadow_d;
      dout_q      <= dout_d;
      irq_q       <= irq_d;
      status_q    <= status_d;
      en_q        <= en_d;
      per_q       <= per_d;
      ie_q        <= ie_d;
      load_q      <= load_d;
      count_q     <= count_d;
    end
  end

  assign dout = dout_q;
  assign irq  = irq_q;

endmodule
